// File: rtl/rib_arbiter_if.sv
// ---------------------------------------------------------------------------
// rib_arbiter_if
// Purpose : bundles the three-master request side and the shared RIB slave
//           channel of rib_arbiter into one interface.
// Modports: master - the arbiter itself. It takes requests from the masters
//                    and acts as bus master towards the shared slave.
//           slave  - the environment: the three masters plus the slave device.
// Signals : m_req_i/m_we_i [3], m_addr_i/m_data_i packed 3 x width (master k
//           at [k*W +: W]), m_data_o/m_ack_o/m_err_o completion,
//           s_req_o/s_we_o/s_addr_o/s_data_o slave request, s_data_i/s_ack_i
//           slave response, grant_o current owner, hold_flag_o core stall.
// ---------------------------------------------------------------------------
interface rib_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [2:0]          m_req_i;
  logic [2:0]          m_we_i;
  logic [3*ADDR_W-1:0] m_addr_i;
  logic [3*DATA_W-1:0] m_data_i;
  logic [DATA_W-1:0]   m_data_o;
  logic [2:0]          m_ack_o;
  logic                m_err_o;
  logic                s_req_o;
  logic                s_we_o;
  logic [ADDR_W-1:0]   s_addr_o;
  logic [DATA_W-1:0]   s_data_o;
  logic [DATA_W-1:0]   s_data_i;
  logic                s_ack_i;
  logic [2:0]          grant_o;
  logic                hold_flag_o;

  modport master (
    input  m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    output m_data_o, m_ack_o, m_err_o, s_req_o, s_we_o, s_addr_o, s_data_o,
           grant_o, hold_flag_o
  );

  modport slave (
    output m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    input  m_data_o, m_ack_o, m_err_o, s_req_o, s_we_o, s_addr_o, s_data_o,
           grant_o, hold_flag_o
  );
endinterface

// File: rtl/rib_arbiter.sv
// ---------------------------------------------------------------------------
// rib_arbiter
// Purpose : registered 3-master arbiter/sequencer for one shared RIB slave.
//           m0 = core load/store, m1 = core fetch, m2 = JTAG debug.
//           Captures the winning request, drives the slave until ack or
//           TIMEOUT busy cycles, then returns a one-cycle ack (+err on timeout).
// Ports   : clk  - system clock
//           rst  - asynchronous reset, active-low
//           bus  - rib_arbiter_if.master (requests, slave channel, grant_o,
//                  hold_flag_o)
// Config  : RIB_ARB_RR_EN defined   -> round-robin arbitration starting at
//                                      (last owner + 1) mod 3
//           RIB_ARB_RR_EN undefined -> fixed priority m2 > m0 > m1
// ---------------------------------------------------------------------------
module rib_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  rib_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Counter starts at 0 on entry to BUSY, so the last busy cycle sees TIMEOUT-1.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_grant, w_grant_nxt;
  logic [2:0]        r_ack, w_ack_nxt;
  logic              r_err, w_err_nxt;
  logic              r_sreq, w_sreq_nxt;
  logic              r_swe, w_swe_nxt;
  logic [ADDR_W-1:0] r_saddr, w_saddr_nxt;
  logic [DATA_W-1:0] r_sdata, w_sdata_nxt;
  logic [DATA_W-1:0] r_mdata, w_mdata_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [2:0]        w_win;
  logic [1:0]        w_win_idx;

`ifdef RIB_ARB_RR_EN
  logic [1:0] r_ptr, w_ptr_nxt;

  function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, ptr} + {1'b0, off};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  // First requester found searching from the pointer wins.
  always_comb begin
    w_win = 3'b000;
    for (int unsigned i = 0; i < 3; i++) begin
      if (w_win == 3'b000 && bus.m_req_i[rr_idx(r_ptr, 2'(i))]) begin
        w_win = 3'b001 << rr_idx(r_ptr, 2'(i));
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (r_state == StIdle && w_win != 3'b000) begin
      unique case (w_win)
        3'b001:  w_ptr_nxt = 2'd1;
        3'b010:  w_ptr_nxt = 2'd2;
        default: w_ptr_nxt = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ptr <= 2'd0;
    else      r_ptr <= w_ptr_nxt;
  end
`else
  always_comb begin
    w_win = 3'b000;
    if (bus.m_req_i[2])      w_win = 3'b100;
    else if (bus.m_req_i[0]) w_win = 3'b001;
    else if (bus.m_req_i[1]) w_win = 3'b010;
  end
`endif

  // One-hot winner to index: 001->0, 010->1, 100->2.
  assign w_win_idx = {w_win[2], w_win[1]};

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ack_nxt   = 3'b000;
    w_err_nxt   = r_err;
    w_sreq_nxt  = r_sreq;
    w_swe_nxt   = r_swe;
    w_saddr_nxt = r_saddr;
    w_sdata_nxt = r_sdata;
    w_mdata_nxt = r_mdata;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt   = 8'd0;
        w_err_nxt   = 1'b0;
        w_grant_nxt = 3'b000;
        if (w_win != 3'b000) begin
          w_state_nxt = StBusy;
          w_grant_nxt = w_win;
          w_sreq_nxt  = 1'b1;
          w_swe_nxt   = bus.m_we_i[w_win_idx];
          w_saddr_nxt = bus.m_addr_i[32'(w_win_idx) * ADDR_W +: ADDR_W];
          w_sdata_nxt = bus.m_data_i[32'(w_win_idx) * DATA_W +: DATA_W];
        end
      end
      StBusy: begin
        // Ack takes precedence over a coincident timeout.
        if (bus.s_ack_i) begin
          w_state_nxt = StDone;
          w_mdata_nxt = bus.s_data_i;
          w_err_nxt   = 1'b0;
          w_sreq_nxt  = 1'b0;
          w_ack_nxt   = r_grant;
        end else if (r_cnt == CntLast) begin
          w_state_nxt = StDone;
          w_mdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_sreq_nxt  = 1'b0;
          w_ack_nxt   = r_grant;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
        w_grant_nxt = 3'b000;
        w_cnt_nxt   = 8'd0;
        w_err_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = StIdle;
        w_grant_nxt = 3'b000;
        w_sreq_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_grant <= 3'b000;
      r_ack   <= 3'b000;
      r_err   <= 1'b0;
      r_sreq  <= 1'b0;
      r_swe   <= 1'b0;
      r_saddr <= '0;
      r_sdata <= '0;
      r_mdata <= '0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_sreq  <= w_sreq_nxt;
      r_swe   <= w_swe_nxt;
      r_saddr <= w_saddr_nxt;
      r_sdata <= w_sdata_nxt;
      r_mdata <= w_mdata_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.grant_o  = r_grant;
  assign bus.m_ack_o  = r_ack;
  assign bus.m_err_o  = r_err;
  assign bus.m_data_o = r_mdata;
  assign bus.s_req_o  = r_sreq;
  assign bus.s_we_o   = r_swe;
  assign bus.s_addr_o = r_saddr;
  assign bus.s_data_o = r_sdata;

  // Gated by rst so every output reads 0 while reset is held.
  assign bus.hold_flag_o = rst & ((r_grant[0] | r_grant[2]) |
                                  ((r_state == StIdle) & (bus.m_req_i[0] | bus.m_req_i[2])));

endmodule
